// File: rtl/onehot_event_encoder_pkg.sv
// Shared types and helpers for the one-hot event encoder.
// Optional rotating priority is enabled with ENC_ROUND_ROBIN_EN.
package enc_pkg;

  localparam int N_REQ = 16;
  localparam int CW    = 4;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  function automatic logic [N_REQ-1:0] onehot16(
    input logic [CW-1:0] idx
  );
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_event_encoder_if.sv
// Valid/ready index stream between the encoder and its consumer.
interface onehot_event_encoder_if;
  import enc_pkg::*;

  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_code;

  modport master (
    output out_valid,
    output out_code,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_code,
    output out_ready
  );

endinterface

// File: rtl/onehot_event_encoder_prio_select.sv
// Priority pick over a 16-bit vector, searching upward from start
// and wrapping 15 -> 0.
module onehot_prio_select
  import enc_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  input  logic [CW-1:0]    start,
  output logic [CW-1:0]    idx,
  output logic             any
);

  logic          found;
  logic [CW-1:0] j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = '0;
    any   = |vec;
    for (int i = 0; i < N_REQ; i++) begin
      j = start + CW'(i);
      if (!found && vec[j]) begin
        idx   = j;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_event_encoder.sv
// Sticky 16-line event collector emitting 4-bit indices on valid/ready.
// ENC_ROUND_ROBIN_EN selects rotating instead of fixed-lowest priority.
module onehot_event_encoder
  import enc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clr,
  input  logic [N_REQ-1:0]       req_in,
  onehot_event_encoder_if.master out_if,
  output logic [N_REQ-1:0]       pending,
  output logic                   ovf
);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [CW-1:0]    code_q, code_d;
  logic             ovf_q, ovf_d;

  logic             hs;
  logic [N_REQ-1:0] grant_mask;
  logic [N_REQ-1:0] remain;
  logic [CW-1:0]    sel_idx;
  logic             sel_any;
  logic [CW-1:0]    start;

`ifdef ENC_ROUND_ROBIN_EN
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (hs && !clr) rr_ptr_d = code_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  assign hs         = (state_q == ST_SEND) && out_if.out_ready;
  assign grant_mask = hs ? onehot16(code_q) : '0;
  // The in-flight bit is excluded so the next pick never repeats it.
  assign remain     = pending_q & ~grant_mask;

  onehot_prio_select u_sel (
    .vec   (remain),
    .start (start),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    pending_d = en ? (remain | req_in) : remain;
    ovf_d     = ovf_q | (en && |(req_in & remain));
    unique case (state_q)
      ST_IDLE: begin
        if (sel_any) begin
          code_d  = sel_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (hs) begin
          if (sel_any) code_d  = sel_idx;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clr) begin
      pending_d = '0;
      state_d   = ST_IDLE;
      ovf_d     = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_if.out_valid = (state_q == ST_SEND);
  assign out_if.out_code  = code_q;
  assign pending          = pending_q;
  assign ovf              = ovf_q;

endmodule
